argmax_classifier: RTL and testbench
====================================

ARGMAX_CLASSIFIER -- requirements
Module: argmax_classifier

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 48, giving the signed score width, which matches the output layer width.
REQ-002 The module SHALL have parameter CLASS_NUM, default 10, giving the number of scores; legal range 2..16.
REQ-003 The module SHALL have parameter IDX_WIDTH, default 4, giving the class index width; it must satisfy 2^IDX_WIDTH >= CLASS_NUM.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port start, input, 1 bit: request to classify the current scores.
REQ-007 Port scores, input, signed [DATA_WIDTH-1:0] array [0:CLASS_NUM-1]: the output-layer results.
REQ-008 Port busy, output, 1 bit: high while in SCAN.
REQ-009 Port out_valid, output, 1 bit: a result is presented.
REQ-010 Port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 Port class_idx, output, [IDX_WIDTH-1:0]: index of the maximum score.
REQ-012 Port max_score, output, signed [DATA_WIDTH-1:0]: value of the maximum score.

Function
REQ-013 The FSM SHALL have three states: IDLE, SCAN and HOLD.
REQ-014 In IDLE, start=1 at a rising edge SHALL snapshot all scores into internal registers, load max_score=scores[0] and class_idx=0, set the scan pointer to 1, and enter SCAN.
REQ-015 In SCAN, each cycle SHALL compare exactly one snapshot entry (at the pointer) against max_score using a signed strict greater-than; if greater, max_score and class_idx SHALL update, and the pointer SHALL increment.
REQ-016 Ties SHALL resolve to the lowest index.
REQ-017 After comparing entry CLASS_NUM-1, the FSM SHALL enter HOLD with out_valid=1.
REQ-018 Latency: start is sampled at edge T, busy=1 during cycles T..T+CLASS_NUM-1, and out_valid rises after edge T+CLASS_NUM-1 (9 SCAN cycles at the default).
REQ-019 In HOLD, out_valid, class_idx and max_score SHALL stay stable until a cycle with out_ready=1; at that edge the FSM SHALL return to IDLE and out_valid SHALL drop.
REQ-020 start SHALL be ignored outside IDLE, including in the HOLD cycle where out_ready=1.
REQ-021 Changes on scores after the snapshot SHALL NOT affect the result in progress.
REQ-022 class_idx and max_score SHALL be valid only while out_valid=1; their values in IDLE and SCAN are intermediate.

Reset
REQ-023 rst_n low SHALL immediately force the FSM to IDLE, busy=0, out_valid=0, class_idx=0, max_score=0, pointer=0 and all snapshot registers to 0.
REQ-024 Reset asserted mid-SCAN or mid-HOLD SHALL discard the operation; no out_valid SHALL follow release of reset unless a new start is given.

Configuration
REQ-025 With macro ARGMAX_RUNNER_UP_EN defined, the module SHALL add output runner_up, signed [DATA_WIDTH-1:0], and output margin, unsigned [DATA_WIDTH:0], equal to max_score minus runner_up.
REQ-026 With the macro defined, runner_up SHALL initialise to -2^(DATA_WIDTH-1) at start.
REQ-027 With the macro defined, each SCAN entry s SHALL update as follows: if s>max, runner_up takes the old max; else if s>runner_up, runner_up takes s. An equal maximum therefore gives margin=0.
REQ-028 With the macro defined, runner_up and margin SHALL reset to 0 and follow the same hold rules as max_score.
REQ-029 Without the macro, these ports and all their logic SHALL be absent, and the core behaviour SHALL be unchanged.

Verification
REQ-030 Scores {0,5,-3,12,7,1,0,2,11,4}, start pulse -> out_valid after 9 SCAN cycles, class_idx=3, max_score=12; runner_up=11 and margin=1 when the macro is enabled.
REQ-031 All scores -7 -> class_idx=0, max_score=-7; runner_up=-7 and margin=0 when the macro is enabled.
REQ-032 Negative extremes: scores[9]=-1 and all others -2^47 -> class_idx=9, max_score=-1.
REQ-033 out_ready held 0 for 20 cycles, with start pulsed and scores changed during HOLD -> outputs stable and no new operation; out_ready=1 for one cycle -> IDLE next cycle, out_valid=0.
REQ-034 rst_n pulsed low during the 4th SCAN cycle -> all outputs 0 asynchronously; after release, no out_valid; a fresh start yields a correct result.
REQ-035 Back-to-back operation: out_ready tied to 1 and start reasserted in the first IDLE cycle -> second result correct, with 11 cycles from start to start.

Source files
------------

// File: rtl/argmax_classifier_if.sv
// Score/result bundle for argmax_classifier; master drives scores and handshake, slave returns result.
// The ARGMAX_RUNNER_UP_EN macro adds the runner_up and margin signals.
interface argmax_classifier_if #(
  parameter int DATA_WIDTH = 48,
  parameter int CLASS_NUM  = 10,
  parameter int IDX_WIDTH  = 4
);
  logic                         start;
  logic signed [DATA_WIDTH-1:0] scores [0:CLASS_NUM-1];
  logic                         busy;
  logic                         out_valid;
  logic                         out_ready;
  logic [IDX_WIDTH-1:0]         class_idx;
  logic signed [DATA_WIDTH-1:0] max_score;
`ifdef ARGMAX_RUNNER_UP_EN
  logic signed [DATA_WIDTH-1:0] runner_up;
  logic [DATA_WIDTH:0]          margin;

  modport master (output start, scores, out_ready,
                  input  busy, out_valid, class_idx, max_score, runner_up, margin);
  modport slave  (input  start, scores, out_ready,
                  output busy, out_valid, class_idx, max_score, runner_up, margin);
`else
  modport master (output start, scores, out_ready,
                  input  busy, out_valid, class_idx, max_score);
  modport slave  (input  start, scores, out_ready,
                  output busy, out_valid, class_idx, max_score);
`endif
endinterface

// File: rtl/argmax_classifier.sv
// Sequential argmax over a snapshot of CLASS_NUM signed scores, one compare per cycle.
// Optional macro ARGMAX_RUNNER_UP_EN adds second-best tracking (runner_up, margin).
module argmax_classifier #(
  parameter int DATA_WIDTH = 48,
  parameter int CLASS_NUM  = 10,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  argmax_classifier_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  state_t                       r_state;
  logic [IDX_WIDTH-1:0]         r_ptr;
  logic signed [DATA_WIDTH-1:0] r_snap [0:CLASS_NUM-1];
  logic signed [DATA_WIDTH-1:0] r_max;
  logic [IDX_WIDTH-1:0]         r_idx;
  logic                         r_busy;
  logic                         r_valid;

  logic signed [DATA_WIDTH-1:0] w_cur;
  logic                         w_gt;
  logic                         w_last;
  logic                         w_load;

  assign w_cur  = r_snap[r_ptr];
  assign w_gt   = w_cur > r_max;
  assign w_last = (r_ptr == IDX_WIDTH'(CLASS_NUM - 1));
  assign w_load = (r_state == IDLE) && bus.start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CLASS_NUM; i++) r_snap[i] <= '0;
    end else if (w_load) begin
      for (int i = 0; i < CLASS_NUM; i++) r_snap[i] <= bus.scores[i];
    end
  end

`ifdef ARGMAX_RUNNER_UP_EN
  localparam logic signed [DATA_WIDTH-1:0] MIN_SCORE = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic signed [DATA_WIDTH-1:0] r_ru;
  logic                         w_gt_ru;

  assign w_gt_ru = w_cur > r_ru;

  // Strict compares keep an equal maximum out of the max path, so it lands in runner_up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ru <= '0;
    end else if (w_load) begin
      r_ru <= MIN_SCORE;
    end else if (r_state == SCAN) begin
      if (w_gt)         r_ru <= r_max;
      else if (w_gt_ru) r_ru <= w_cur;
    end
  end

  assign bus.runner_up = r_ru;
  assign bus.margin    = {r_max[DATA_WIDTH-1], r_max} - {r_ru[DATA_WIDTH-1], r_ru};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_max   <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_max   <= bus.scores[0];
            r_idx   <= '0;
            r_ptr   <= IDX_WIDTH'(1);
            r_busy  <= 1'b1;
            r_state <= SCAN;
          end
        end
        SCAN: begin
          if (w_gt) begin
            r_max <= w_cur;
            r_idx <= r_ptr;
          end
          r_ptr <= r_ptr + IDX_WIDTH'(1);
          if (w_last) begin
            r_busy  <= 1'b0;
            r_valid <= 1'b1;
            r_state <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_valid <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.out_valid = r_valid;
  assign bus.class_idx = r_idx;
  assign bus.max_score = r_max;

endmodule

// File: tb/tb_argmax_classifier.sv
// Scoreboard bench for argmax_classifier: directed vectors push expectations, a monitor pops on accept.
module tb_argmax_classifier;

  typedef logic signed [47:0] vec_t [0:9];
  typedef struct {
    logic [3:0]         idx;
    logic signed [47:0] mx;
    logic signed [47:0] ru;
    logic [48:0]        mg;
  } exp_t;

  localparam logic signed [47:0] MINV = {1'b1, 47'b0};

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  int   cyc;
  exp_t sb_q [$];
  exp_t mon_e;

  argmax_classifier_if #(.DATA_WIDTH(48), .CLASS_NUM(10), .IDX_WIDTH(4)) bus ();

  argmax_classifier #(.DATA_WIDTH(48), .CLASS_NUM(10), .IDX_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        $display("txn class_idx=%0d max_score=%0d (expected %0d / %0d)",
                 bus.class_idx, bus.max_score, mon_e.idx, mon_e.mx);
        check("class_idx", 64'(bus.class_idx), 64'(mon_e.idx));
        check("max_score", 64'(bus.max_score), 64'(mon_e.mx));
`ifdef ARGMAX_RUNNER_UP_EN
        check("runner_up", 64'(bus.runner_up), 64'(mon_e.ru));
        check("margin",    64'(bus.margin),    64'(mon_e.mg));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] idx, input logic signed [47:0] mx,
                      input logic signed [47:0] ru, input logic [48:0] mg);
    exp_t e;
    e.idx = idx; e.mx = mx; e.ru = ru; e.mg = mg;
    sb_q.push_back(e);
  endtask

  task automatic start_op(input vec_t v);
    bus.scores = v;
    bus.start  = 1'b1;
    tick();
    bus.start  = 1'b0;
  endtask

  task automatic wait_valid(output int nbusy);
    bit got;
    got   = 1'b0;
    nbusy = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
      else if (bus.busy) nbusy++;
    end
    if (!got) check("valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int nb;
    start_op(v);
    wait_valid(nb);
    tick();
  endtask

  vec_t v1, v2, v3, v4, v5, v6, vjunk;
  int   nbusy;
  int   cyc1;
  int   seen;
  bit   hold_bad;
  logic [3:0]         h_idx;
  logic signed [47:0] h_max;

  initial begin
    total = 0;
    bad   = 0;
    v1 = '{48'sd0, 48'sd5, -48'sd3, 48'sd12, 48'sd7, 48'sd1, 48'sd0, 48'sd2, 48'sd11, 48'sd4};
    v2 = '{-48'sd7, -48'sd7, -48'sd7, -48'sd7, -48'sd7, -48'sd7, -48'sd7, -48'sd7, -48'sd7, -48'sd7};
    v3 = '{MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, -48'sd1};
    v4 = '{48'sd1, 48'sd9, 48'sd2, 48'sd9, 48'sd0, 48'sd0, 48'sd0, 48'sd0, 48'sd0, 48'sd0};
    v5 = '{-48'sd5, -48'sd4, -48'sd3, -48'sd2, -48'sd1, 48'sd0, 48'sd1, 48'sd2, 48'sd3, 48'sd100};
    v6 = '{48'sd50, 48'sd40, 48'sd30, 48'sd20, 48'sd10, 48'sd0, -48'sd10, -48'sd20, -48'sd30, -48'sd40};
    vjunk = '{48'sd99, 48'sd99, 48'sd99, 48'sd99, 48'sd99, 48'sd99, 48'sd99, 48'sd99, 48'sd99, 48'sd999};

    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.out_ready = 1'b0;
    bus.scores    = v2;
    #3;
    check("rst_busy",      64'(bus.busy),      64'd0);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_class_idx", 64'(bus.class_idx), 64'd0);
    check("rst_max_score", 64'(bus.max_score), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Latency and HOLD stability with out_ready low.
    push(4'd3, 48'sd12, 48'sd11, 49'd1);
    start_op(v1);
    wait_valid(nbusy);
    check("busy_cycles", 64'(nbusy), 64'd9);
    h_idx    = bus.class_idx;
    h_max    = bus.max_score;
    hold_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      bus.scores = (i % 2 == 0) ? vjunk : v3;
      bus.start  = (i % 3 == 0);
      @(negedge clk);
      if (!bus.out_valid || bus.busy || bus.class_idx !== h_idx || bus.max_score !== h_max)
        hold_bad = 1'b1;
    end
    check("hold_stable", 64'(hold_bad), 64'd0);
    tick();
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    @(negedge clk);
    check("accept_out_valid", 64'(bus.out_valid), 64'd0);
    check("accept_busy",      64'(bus.busy),      64'd0);
    tick();

    bus.out_ready = 1'b1;
    push(4'd0, -48'sd7, -48'sd7, 49'd0);
    run_vec(v2);
    push(4'd9, -48'sd1, MINV, 49'h7FFF_FFFF_FFFF);
    run_vec(v3);
    push(4'd1, 48'sd9, 48'sd9, 49'd0);
    run_vec(v4);

    // Reset in the 4th SCAN cycle discards the operation.
    start_op(v1);
    tick();
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("midscan_busy",      64'(bus.busy),      64'd0);
    check("midscan_out_valid", 64'(bus.out_valid), 64'd0);
    check("midscan_class_idx", 64'(bus.class_idx), 64'd0);
    check("midscan_max_score", 64'(bus.max_score), 64'd0);
    tick();
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("no_valid_after_reset", 64'(seen), 64'd0);
    tick();
    push(4'd0, 48'sd50, 48'sd40, 49'd10);
    run_vec(v6);

    // Back-to-back: restart in the first IDLE cycle after acceptance.
    push(4'd3, 48'sd12, 48'sd11, 49'd1);
    start_op(v1);
    cyc1 = cyc;
    wait_valid(nbusy);
    tick();
    push(4'd9, 48'sd100, 48'sd3, 49'd97);
    start_op(v5);
    check("start_to_start", 64'(cyc - cyc1), 64'd11);
    wait_valid(nbusy);
    tick();
    tick();

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
